// File: rtl/dma_pkg.sv
// Shared types and helpers for the memory-to-stream DMA engine.
// Widths here are the engine's default configuration.
package dma_pkg;

  localparam int DMA_BUS_W  = 64;
  localparam int DMA_ADDR_W = 32;
  localparam int DMA_LEN_W  = 32;

  function automatic int bpb(int bus_width);
    return bus_width / 8;
  endfunction

  localparam int DMA_BPB = bpb(DMA_BUS_W);

  typedef struct packed {
    logic [DMA_ADDR_W-1:0] addr;
    logic [DMA_LEN_W-1:0]  bytes;
  } desc_t;

  typedef struct packed {
    logic [DMA_BPB-1:0] keep;
    logic               last;
  } meta_t;

  function automatic logic [DMA_BPB-1:0] keep_mask(int rem);
    logic [DMA_BPB-1:0] m;
    m = '0;
    for (int i = 0; i < DMA_BPB; i++) begin
      m[i] = (i < rem);
    end
    return m;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is taken
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/axis_dma_m2s_engine.sv
// Memory-to-stream DMA: descriptor queue, credit-limited read issue,
// and an AXI-Stream packet per descriptor with partial final keep.
module axis_dma_m2s_engine
  import dma_pkg::*;
#(
  parameter int BUS_WIDTH       = DMA_BUS_W,
  parameter int ADDR_W          = DMA_ADDR_W,
  parameter int LEN_W           = DMA_LEN_W,
  parameter int DESC_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     desc_valid,
  output logic                     desc_ready,
  input  logic [ADDR_W-1:0]        desc_addr,
  input  logic [LEN_W-1:0]         desc_bytes,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [ADDR_W-1:0]        mem_req_addr,
  input  logic                     mem_rsp_valid,
  input  logic [BUS_WIDTH-1:0]     mem_rsp_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [BUS_WIDTH-1:0]     m_data,
  output logic [BUS_WIDTH/8-1:0]   m_keep,
  output logic                     m_last,
  output logic                     busy,
  output logic                     desc_done
);

  localparam int BPB   = bpb(BUS_WIDTH);
  localparam int OFF_W = $clog2(BPB);
  localparam int CRD_W = $clog2(MAX_OUTSTANDING) + 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  desc_t desc_in, desc_head;
  meta_t meta_in, meta_head;
  logic  desc_full, desc_empty, desc_pop;
  logic  meta_full, meta_empty, data_full, data_empty;
  logic  fifo_unused;
  logic [BUS_WIDTH-1:0] data_head;
  logic [BPB-1:0]       keep_v;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  beats_q, beats_d;
  logic [OFF_W-1:0]  rem_q, rem_d;
  logic [CRD_W-1:0]  credit_q, credit_d;
  logic              req_hs, beat_hs, last_beat;

  assign desc_in    = '{addr: desc_addr, bytes: desc_bytes};
  assign desc_ready = !desc_full;

  sync_fifo #(.WIDTH($bits(desc_t)), .DEPTH(DESC_DEPTH)) u_desc_q (
    .clk(aclk), .rst(areset),
    .push(desc_valid && !desc_full), .wdata(desc_in),
    .pop(desc_pop), .rdata(desc_head),
    .full(desc_full), .empty(desc_empty)
  );

  assign mem_req_valid = (state_q == S_ISSUE) && (credit_q != '0);
  assign mem_req_addr  = addr_q;
  assign req_hs        = mem_req_valid && mem_req_ready;
  assign last_beat     = (beats_q == LEN_W'(1));
  assign desc_pop      = !desc_empty &&
                         ((state_q == S_IDLE) || (req_hs && last_beat));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    beats_d  = beats_q;
    rem_d    = rem_q;
    if (req_hs) begin
      addr_d  = addr_q + ADDR_W'(BPB);
      beats_d = beats_q - LEN_W'(1);
      if (last_beat) state_d = S_IDLE;
    end
    // Zero-length descriptors are dropped here without entering ISSUE.
    if (desc_pop) begin
      addr_d  = desc_head.addr;
      beats_d = (desc_head.bytes >> OFF_W) +
                LEN_W'(|desc_head.bytes[OFF_W-1:0]);
      rem_d   = desc_head.bytes[OFF_W-1:0];
      state_d = (desc_head.bytes == '0) ? S_IDLE : S_ISSUE;
    end
    credit_d = credit_q - CRD_W'(req_hs) + CRD_W'(beat_hs);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      beats_q  <= '0;
      rem_q    <= '0;
      credit_q <= CRD_W'(MAX_OUTSTANDING);
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      beats_q  <= beats_d;
      rem_q    <= rem_d;
      credit_q <= credit_d;
    end
  end

  assign meta_in.keep = (last_beat && rem_q != '0) ?
                        keep_mask(int'(rem_q)) : '1;
  assign meta_in.last = last_beat;

  sync_fifo #(.WIDTH($bits(meta_t)), .DEPTH(MAX_OUTSTANDING)) u_meta_q (
    .clk(aclk), .rst(areset),
    .push(req_hs), .wdata(meta_in),
    .pop(beat_hs), .rdata(meta_head),
    .full(meta_full), .empty(meta_empty)
  );

  // Credit keeps occupancy bounded, so responses are never refused.
  sync_fifo #(.WIDTH(BUS_WIDTH), .DEPTH(MAX_OUTSTANDING)) u_data_q (
    .clk(aclk), .rst(areset),
    .push(mem_rsp_valid), .wdata(mem_rsp_data),
    .pop(beat_hs), .rdata(data_head),
    .full(data_full), .empty(data_empty)
  );

  assign fifo_unused = meta_full ^ meta_empty ^ data_full;

  assign m_valid   = !data_empty;
  assign beat_hs   = m_valid && m_ready;
  assign keep_v    = m_valid ? meta_head.keep : '0;
  assign m_keep    = keep_v;
  assign m_last    = m_valid && meta_head.last;
  assign desc_done = beat_hs && meta_head.last;

  always_comb begin
    m_data = '0;
    for (int i = 0; i < BPB; i++) begin
      if (keep_v[i]) m_data[8*i +: 8] = data_head[8*i +: 8];
    end
  end

  assign busy = !desc_empty || (state_q != S_IDLE) ||
                (credit_q != CRD_W'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_axis_dma_m2s_engine.sv
// Directed and randomized bench for axis_dma_m2s_engine with a
// byte-level packet model and a one-cycle memory responder.
module tb_axis_dma_m2s_engine;

  logic        aclk = 1'b0;
  logic        areset;
  logic        desc_valid, desc_ready;
  logic [31:0] desc_addr, desc_bytes;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        m_valid, m_ready;
  logic [63:0] m_data;
  logic [7:0]  m_keep;
  logic        m_last, busy, desc_done;

  always #5 aclk = ~aclk;

  axis_dma_m2s_engine dut (
    .aclk(aclk), .areset(areset),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_addr(desc_addr), .desc_bytes(desc_bytes),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_keep(m_keep), .m_last(m_last),
    .busy(busy), .desc_done(desc_done)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] off_a[$];
  logic [31:0] off_b[$];
  int          beat_cyc[$];
  int checks = 0, errors = 0;
  int cyc = 0, n_beats = 0, n_done = 0, n_req = 0;
  int m_pct = 100, r_pct = 100;
  bit          nx_rsp_v;
  logic [63:0] nx_rsp_d;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] + 8'(a[15:8] * 3) + 8'(a[31:24] * 5) + 8'h11;
  endfunction

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = mem_byte(a + 32'(i));
    return w;
  endfunction

  task automatic model_desc(input logic [31:0] a, input int n);
    for (int b = 0; 8 * b < n; b++) begin
      beat_t e;
      int cnt;
      cnt = (n - 8 * b > 8) ? 8 : n - 8 * b;
      e.d = '0;
      e.k = '0;
      for (int i = 0; i < cnt; i++) begin
        e.d[8*i +: 8] = mem_byte(a + 32'(8 * b + i));
        e.k[i] = 1'b1;
      end
      e.l = (8 * b + 8 >= n);
      exp_q.push_back(e);
    end
  endtask

  task automatic offer(input logic [31:0] a, input logic [31:0] n);
    off_a.push_back(a);
    off_b.push_back(n);
    desc_valid = 1'b1;
    desc_addr  = off_a[0];
    desc_bytes = off_b[0];
  endtask

  task automatic tick();
    bit dhs;
    beat_t e;
    dhs = 0;
    @(negedge aclk);
    if (areset) begin
      nx_rsp_v = 0;
    end else begin
      nx_rsp_v = mem_req_valid && mem_req_ready;
      nx_rsp_d = mem_word(mem_req_addr);
      if (nx_rsp_v) n_req++;
      if (desc_valid && desc_ready) begin
        dhs = 1;
        model_desc(desc_addr, int'(desc_bytes));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 128'(m_valid), 128'(0));
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 128'(m_data), 128'(e.d));
          chk("beat_keep", 128'(m_keep), 128'(e.k));
          chk("beat_last", 128'(m_last), 128'(e.l));
          chk("desc_done", 128'(desc_done), 128'(e.l));
        end
        n_beats++;
        beat_cyc.push_back(cyc);
      end else begin
        chk("done_idle", 128'(desc_done), 128'(0));
      end
      if (desc_done) n_done++;
    end
    @(posedge aclk);
    #1;
    cyc++;
    if (dhs) begin
      void'(off_a.pop_front());
      void'(off_b.pop_front());
    end
    desc_valid    = off_a.size() > 0;
    desc_addr     = desc_valid ? off_a[0] : '0;
    desc_bytes    = desc_valid ? off_b[0] : '0;
    mem_rsp_valid = nx_rsp_v;
    mem_rsp_data  = nx_rsp_v ? nx_rsp_d : '0;
    m_ready       = int'($urandom_range(99)) < m_pct;
    mem_req_ready = int'($urandom_range(99)) < r_pct;
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || off_a.size() != 0 || busy) && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 128'(k >= budget), 128'(0));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_m_valid"}, 128'(m_valid), 128'(0));
    chk({tag, "_req_valid"}, 128'(mem_req_valid), 128'(0));
    chk({tag, "_req_addr"}, 128'(mem_req_addr), 128'(0));
    chk({tag, "_m_data"}, 128'(m_data), 128'(0));
    chk({tag, "_m_keep"}, 128'(m_keep), 128'(0));
    chk({tag, "_m_last"}, 128'(m_last), 128'(0));
    chk({tag, "_done"}, 128'(desc_done), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_desc_ready"}, 128'(desc_ready), 128'(1));
  endtask

  task automatic clr();
    n_beats = 0;
    n_done  = 0;
    n_req   = 0;
    beat_cyc.delete();
  endtask

  initial begin
    logic [63:0] sd;
    logic [7:0]  sk;
    logic        sl;
    bit          snap;
    int          unstable, k;

    areset = 1'b1;
    desc_valid = 0; desc_addr = '0; desc_bytes = '0;
    mem_req_ready = 1; mem_rsp_valid = 0; mem_rsp_data = '0;
    m_ready = 1;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    check_idle("reset");

    // single partial packet: 20 bytes -> 3 beats
    clr();
    offer(32'h100, 20);
    drain("t1_drain", 200);
    chk("t1_beats", 128'(n_beats), 128'(3));
    chk("t1_done", 128'(n_done), 128'(1));
    chk("t1_busy", 128'(busy), 128'(0));

    // exact multiple, then a zero-length descriptor
    clr();
    offer(32'h0, 16);
    offer(32'h0, 0);
    drain("t2_drain", 200);
    chk("t2_beats", 128'(n_beats), 128'(2));
    chk("t2_done", 128'(n_done), 128'(1));

    // back-to-back single-beat packets
    clr();
    for (int i = 0; i < 4; i++) offer(32'h300 + 32'(8 * i), 8);
    drain("t3_drain", 200);
    chk("t3_beats", 128'(n_beats), 128'(4));
    chk("t3_done", 128'(n_done), 128'(4));
    if (beat_cyc.size() == 4)
      chk("t3_no_bubble", 128'(beat_cyc[3] - beat_cyc[0]), 128'(3));
    else
      chk("t3_beat_cnt", 128'(beat_cyc.size()), 128'(4));

    // full backpressure: credit limit and queue-full boundary
    clr();
    m_pct = 0;
    m_ready = 0;
    offer(32'h200, 64);
    offer(32'h400, 64);
    for (int i = 0; i < 5; i++) offer(32'h600 + 32'(8 * i), 8);
    snap = 0;
    unstable = 0;
    repeat (50) begin
      tick();
      if (m_valid) begin
        if (!snap) begin
          snap = 1; sd = m_data; sk = m_keep; sl = m_last;
        end else if ({m_data, m_keep, m_last} !== {sd, sk, sl}) begin
          unstable++;
        end
      end
    end
    chk("t4_reqs", 128'(n_req), 128'(8));
    chk("t4_req_valid", 128'(mem_req_valid), 128'(0));
    chk("t4_m_valid", 128'(m_valid), 128'(1));
    chk("t4_stable", 128'(unstable), 128'(0));
    chk("t4_desc_ready", 128'(desc_ready), 128'(0));
    chk("t4_no_beats", 128'(n_beats), 128'(0));
    m_pct = 100;
    drain("t4_drain", 600);
    chk("t4_beats", 128'(n_beats), 128'(21));
    chk("t4_done", 128'(n_done), 128'(7));

    // random backpressure on both sides, including address wrap
    clr();
    m_pct = 20;
    r_pct = 20;
    offer(32'hFFFF_FFF0, 40);
    for (int i = 1; i < 100; i++)
      offer({$urandom() >> 3, 3'b000}, 32'($urandom_range(300, 1)));
    drain("t5_drain", 60000);
    chk("t5_done", 128'(n_done), 128'(100));
    chk("t5_left", 128'(exp_q.size()), 128'(0));

    // reset in the middle of a 5-beat packet
    clr();
    m_pct = 100;
    r_pct = 100;
    offer(32'h0, 40);
    k = 0;
    while (n_beats < 2 && k < 100) begin
      tick();
      k++;
    end
    chk("t6_two_beats", 128'(n_beats), 128'(2));
    areset = 1'b1;
    mem_rsp_valid = 1'b0;
    exp_q.delete();
    tick();
    areset = 1'b0;
    mem_rsp_valid = 1'b0;
    check_idle("t6_rst");
    clr();
    offer(32'h40, 8);
    drain("t6_drain", 200);
    chk("t6_beats", 128'(n_beats), 128'(1));
    chk("t6_done", 128'(n_done), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
